// File: rtl/seven_segment_scanner.sv
// Time-multiplexed 7-segment driver: double-buffered digit data, programmable slot
// and dead time, blanking/blinking/leading-zero suppression, registered outputs.
module seven_segment_scanner #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int DEAD_CYCLES  = 500,
    parameter int BLINK_FRAMES = 100,
    parameter int HEX_MODE     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digitsIn,
    input  logic [DIGITS-1:0]     dpIn,
    input  logic [DIGITS-1:0]     blankMask,
    input  logic [DIGITS-1:0]     blinkMask,
    input  logic                  lzsIn,
    output logic [6:0]            segmentOut,
    output logic                  dpOut,
    output logic [DIGITS-1:0]     digitSelect,
    output logic                  frameStart
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int DW = 4 * DIGITS;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] DEAD_LIM   = PW'(DEAD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [DW-1:0]     dig;
        logic [DIGITS-1:0] dp;
        logic [DIGITS-1:0] blank;
        logic [DIGITS-1:0] blink;
        logic              lzs;
    } frame_t;

    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic              bphase_q, bphase_d;
    frame_t            pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    frame_t            act_q, act_d;
    logic [6:0]        seg_q, seg_d;
    logic              dpo_q, dpo_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic              fs_q, fs_d;

    frame_t            incoming;
    logic              slot_end;
    logic              frame_end;
    logic [3:0]        cur_val;
    logic [DIGITS-1:0] upper_zero;
    logic              zero_acc;
    logic              dark;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    always_comb begin
        incoming.dig   = digitsIn;
        incoming.dp    = dpIn;
        incoming.blank = blankMask;
        incoming.blink = blinkMask;
        incoming.lzs   = lzsIn;
    end

    assign slot_end  = (presc_q == PRESC_LAST);
    assign frame_end = enable && slot_end && (idx_q == IDX_LAST);

    // Scan position, blink timing and buffer hand-over.
    always_comb begin
        presc_d    = presc_q;
        idx_d      = idx_q;
        bcnt_d     = bcnt_q;
        bphase_d   = bphase_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        act_d      = act_q;

        if (enable) begin
            if (slot_end) begin
                presc_d = '0;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        if (load) begin
            pend_d     = incoming;
            pend_vld_d = 1'b1;
        end

        if (frame_end) begin
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d   = '0;
                bphase_d = ~bphase_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
            // A load landing on the boundary edge bypasses the pending buffer.
            if (load) begin
                act_d      = incoming;
                pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
                act_d      = pend_q;
                pend_vld_d = 1'b0;
            end
        end
    end

    // upper_zero[k] is set when digits k..DIGITS-1 of the active buffer are all zero.
    always_comb begin
        upper_zero = '0;
        zero_acc   = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_acc      = zero_acc & (act_q.dig[4*k +: 4] == 4'd0);
            upper_zero[k] = zero_acc;
        end
    end

    assign cur_val = act_q.dig[{idx_q, 2'b00} +: 4];

    always_comb begin
        dark = act_q.blank[idx_q]
            || (act_q.blink[idx_q] && bphase_q)
            || (act_q.lzs && (idx_q != '0) && upper_zero[idx_q])
            || ((HEX_MODE == 0) && (cur_val > 4'd9));

        seg_d = 7'b1111111;
        dpo_d = 1'b1;
        sel_d = '1;
        fs_d  = 1'b0;
        if (enable) begin
            seg_d = dark ? 7'b1111111 : decode(cur_val);
            dpo_d = dark | ~act_q.dp[idx_q];
            if (presc_q >= DEAD_LIM) begin
                sel_d = ~(DIGITS'(1) << idx_q);
            end
            fs_d = (presc_q == '0) && (idx_q == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            idx_q      <= '0;
            bcnt_q     <= '0;
            bphase_q   <= 1'b0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            act_q      <= '0;
            seg_q      <= 7'b1111111;
            dpo_q      <= 1'b1;
            sel_q      <= '1;
            fs_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            bcnt_q     <= bcnt_d;
            bphase_q   <= bphase_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            act_q      <= act_d;
            seg_q      <= seg_d;
            dpo_q      <= dpo_d;
            sel_q      <= sel_d;
            fs_q       <= fs_d;
        end
    end

    assign segmentOut  = seg_q;
    assign dpOut       = dpo_q;
    assign digitSelect = sel_q;
    assign frameStart  = fs_q;

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Parametrised, time-multiplexed driver for a bank of common-segment 7-segment digits. It decodes DIGITS 4-bit values in 0-9 or hex mode and scans one digit at a time with programmable slot length and anti-ghosting dead time. It adds per-digit decimal point, blanking, blinking and leading-zero suppression, and double-buffers its inputs so a display update never tears mid-frame. It sits between the clock/counter logic and the board's segment and digit-enable pins, replacing per-digit static decoders.

## Interface
Parameters:
- DIGITS, 4: number of digits scanned (≥2).
- SCAN_DIV, 50000: clock cycles per digit slot (≥2).
- DEAD_CYCLES, 500: cycles at slot start with all digits disabled (0 ≤ DEAD_CYCLES < SCAN_DIV).
- BLINK_FRAMES, 100: full frames per blink half-period (≥1).
- HEX_MODE, 0: 1 decodes 10-15 as A,b,C,d,E,F; 0 blanks 10-15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 scans; 0 freezes scan state and turns the display off.
- load  in  1  one-cycle strobe that captures all data inputs into the pending buffer.
- digitsIn  in  4*DIGITS  digit k is in bits [4k+3:4k]; digit 0 is least significant.
- dpIn  in  DIGITS  decimal point per digit, 1 = lit.
- blankMask  in  DIGITS  1 = digit forced dark.
- blinkMask  in  DIGITS  1 = digit blinks.
- lzsIn  in  1  1 = leading-zero suppression on.
- segmentOut  out  7  {g,f,e,d,c,b,a}, active-low.
- dpOut  out  1  active-low.
- digitSelect  out  DIGITS  one-hot, active-low digit enable.
- frameStart  out  1  one-cycle pulse at the start of each digit-0 slot.

## Operation
- State: prescaler (0..SCAN_DIV-1), digit index idx (0..DIGITS-1), pending buffer plus pending flag, active buffer, blink frame counter, blink phase.
- With enable=1, prescaler increments every cycle. At SCAN_DIV-1 it wraps to 0 and idx advances. idx wraps from DIGITS-1 to 0; this is a frame boundary.
- load=1 copies all five data inputs into the pending buffer and sets the pending flag. Repeated loads before a frame boundary: last load wins.
- At a frame boundary with pending set, the pending buffer copies to the active buffer and pending clears. If load and the boundary coincide, the new load data is transferred at that boundary.
- The blink counter increments at each frame boundary. At BLINK_FRAMES-1 it wraps and the blink phase toggles.
- Display of digit idx, evaluated from the active buffer:
  - Dark if blankMask[idx] is set.
  - Dark if blinkMask[idx] is set and blink phase = 1.
  - Dark if lzs is on, idx ≠ 0, and every digit idx..DIGITS-1 is 0.
  - Otherwise segments show the decoded value.
  - Dark means segmentOut=7'b1111111 and dpOut=1. dpIn is suppressed only when the digit is dark.
- Decode table (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - With HEX_MODE=0, values 10-15 are dark.
- digitSelect drives bit idx low only while prescaler ≥ DEAD_CYCLES. Otherwise it is all ones.
- enable=0: prescaler, idx and the blink state hold; outputs go dark and all digits are disabled. load is still accepted. When enable returns to 1, the scan resumes from the held state.

## Timing
- All outputs are registered and lag the internal (prescaler, idx) state by exactly one clock.
- Reset (asynchronous, immediate, also mid-scan):
  - segmentOut=7'b1111111, dpOut=1, digitSelect=all ones, frameStart=0.
  - prescaler=0, idx=0, blink counter=0, blink phase=0.
  - Both buffers and the pending flag = 0.
- First rising edge after rst_n rises, with enable=1: prescaler=0, idx=0. Outputs reflect this one edge later.
- Slot length is exactly SCAN_DIV cycles. Frame length is DIGITS*SCAN_DIV cycles. Digit-lit time per slot is SCAN_DIV-DEAD_CYCLES cycles.
- frameStart is high for the single output cycle that corresponds to prescaler=0, idx=0 (enable=1). It also fires for the first slot after reset.
- Load-to-display latency: the first frame boundary after the load edge. Worst case is one frame.

## Test plan
Bench parameters: DIGITS=4, SCAN_DIV=4, DEAD_CYCLES=1, BLINK_FRAMES=2, HEX_MODE=0.
- Reset check: hold rst_n=0 -> segmentOut=1111111, dpOut=1, digitSelect=1111, frameStart=0. Assert rst_n low mid-slot -> same values in the same cycle, without waiting for a clock.
- Load and scan: load digitsIn=0x1234, dpIn=0100 -> from the next frame, slots show 4,3,2,1 with digitSelect 1110,1101,1011,0111. Each select is low 3 of 4 cycles. dpOut=0 only in the idx=2 slot. frameStart pulses every 16 cycles.
- Leading-zero suppression: digitsIn=0x0070, lzsIn=1 -> digits 3 and 2 dark, digit 1 = 1111000, digit 0 = 1000000. With digitsIn=0x0000, only digit 0 shows 0.
- Blink and blank: blinkMask=0001, blankMask=1000 -> digit 0 is lit for 2 frames and dark for 2 frames, repeating; digit 3 is always dark. Digit value 0xA with HEX_MODE=0 -> dark.
- Double buffering: load 0x1111 mid-frame, then load 0x2222 before the boundary -> the current frame is unchanged, and the next frame shows only 2s. A load on the boundary cycle is applied at that boundary.
- Enable gating: drop enable for 10 cycles mid-slot -> dark output and digitSelect=1111; on re-enable, scanning resumes with the same idx and remaining slot count.
